irq_request_ctrl: RTL and testbench
===================================

# irq_request_ctrl

Source-side interrupt front end for the three-level nested interrupt scheme in the PC unit. It takes three asynchronous external request inputs (push-buttons or peripheral strobes) and synchronises and edge-detects them. It then holds each request as a level `interruptN` until the PC acknowledges it by raising `interruptN_running`, and tracks service until `interruptN_done`. It sits between board I/O and the PC/decoder, with a one-deep re-request queue, masking, per-level service counters and a sticky drop flag.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per raw input; legal values 2..3.
- `CNT_W`, 8: width of each per-level service counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `key_in`  in  3  raw asynchronous requests; bit 0 = level 1 (lowest) … bit 2 = level 3 (highest).
- `mask`  in  3  per-level enable; 1 = level enabled.
- `interrupt1_running`, `interrupt2_running`, `interrupt3_running`  in  1 each  acknowledge/in-service from the PC.
- `interrupt1_done`, `interrupt2_done`, `interrupt3_done`  in  1 each  return-from-interrupt pulse from the decoder.
- `interrupt1`, `interrupt2`, `interrupt3`  out  1 each  request levels to the PC.
- `pending`  out  3  a request is latched, not yet acknowledged (`{L3,L2,L1}`).
- `queued`  out  3  a second request arrived while the level was in service.
- `drop_flag`  out  3  sticky; a request was lost. Cleared only by `clr`.
- `svc_cnt1`, `svc_cnt2`, `svc_cnt3`  out  `CNT_W` each  completed-service counts.

## Operation
- Input path, per bit:
  - The bit passes through `SYNC_STAGES` flops, then a 1-flop history.
  - `rise` = synced & ~history, a one-cycle pulse.
- Per-level FSM. States: IDLE, PEND, ACT.
  - IDLE → PEND on `rise & mask[n]`. A rise while masked is ignored and does not set `drop_flag`.
  - PEND: `interruptN` = 1 and `pending[n]` = 1.
    - A further rise is merged: no queue, no drop.
    - PEND → ACT on the first cycle `interruptN_running` is sampled 1.
    - If `mask[n]` falls while in PEND: PEND → IDLE and the request is discarded.
  - ACT: `interruptN` = 0.
    - A rise sets `queued[n]` if it is clear. If `queued[n]` is already set, `drop_flag[n]` is set.
    - ACT → IDLE on `interruptN_done` with `queued[n]` = 0.
    - ACT → PEND on `interruptN_done` with `queued[n]` = 1. `queued[n]` is cleared on the same edge.
    - A `done` pulse sampled in ACT increments `svc_cntN`, wrapping modulo 2^`CNT_W` without a flag.
    - `running` falling without `done` has no effect; ACT is left only on `done`.
- A `done` pulse while in IDLE or PEND is ignored: no state change, no count.
- Levels are independent. Priority and nesting are resolved by the PC, so several `interruptN` may be high together.
- Simultaneous events in one cycle:
  - `done` and `rise` in ACT: the rise is applied first (sets `queued`), then `done` is evaluated. The result is PEND with `queued` = 0, with no drop.
  - `running` and `rise` in PEND: the state goes to ACT and the rise is merged (not queued).

## Timing
- Reset (`clr` = 1, asynchronous):
  - All FSMs go to IDLE.
  - All outputs go to 0: `interruptN`, `pending`, `queued`, `drop_flag`, `svc_cntN`.
  - Synchroniser and history flops go to 0.
  - A key held high through reset release produces no rise until it has been seen low.
- Reset mid-service (ACT or PEND) discards the request. Any subsequent `done` is ignored as described above.
- Request latency with the default `SYNC_STAGES` = 2:
  - `key_in` rises and is stable before edge k.
  - `rise` is high after edge k+2.
  - `interruptN` = 1 after edge k+3.
  - Latency is `SYNC_STAGES`+1 edges.
- Acknowledge: `running` sampled 1 at edge m → `interruptN` = 0 after edge m. It is registered, so it stays high for the cycle in which `running` is first seen.
- Re-request after `done` at edge d → `interruptN` = 1 after edge d.
- Raw key pulses shorter than one clock period may be missed; debouncing is outside this block.

## Test plan
- Single request, level 2:
  - Stimulus: `mask` = 3'b111; pulse `key_in[1]`; drive `interrupt2_running` high 5 cycles later; pulse `interrupt2_done` 10 cycles after that.
  - Required: `interrupt2` high exactly 3 cycles after the key edge; low on the `running` edge; `pending[1]` tracks it; `svc_cnt2` = 1; FSM back in IDLE.
- Queue and drop, level 3:
  - Stimulus: while in ACT, apply 3 key rises.
  - Required: first rise sets `queued[2]`; second and third set `drop_flag[2]`. On `done`, `interrupt3` re-asserts the next cycle and `queued[2]` = 0.
- Masking, level 1:
  - Stimulus: key rise with `mask[0]` = 0.
  - Required: no `interrupt1`, no drop.
  - Stimulus: request in PEND, then `mask[0]` cleared.
  - Required: `interrupt1` falls after one edge; `pending[0]` = 0.
- Simultaneous `done` + `rise` in ACT:
  - Required: next state PEND, `interrupt` = 1, `queued` = 0, no drop, counter +1.
- Counter wrap: 256 complete services on level 1 → `svc_cnt1` = 0.
- Asynchronous reset:
  - Stimulus: assert `clr` mid-cycle during ACT with `queued` set.
  - Required: all outputs 0 immediately. After release, with the key held high, no request; a later `done` pulse does not change the counter.

Source files
------------

// File: rtl/irq_request_ctrl_if.sv
// irq_request_ctrl bus: raw requests, masks and PC handshake.
// The master side is the board/PC, the slave side is the controller.
interface irq_request_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       key_in;
    logic [2:0]       mask;
    logic             interrupt1_running;
    logic             interrupt2_running;
    logic             interrupt3_running;
    logic             interrupt1_done;
    logic             interrupt2_done;
    logic             interrupt3_done;
    logic             interrupt1;
    logic             interrupt2;
    logic             interrupt3;
    logic [2:0]       pending;
    logic [2:0]       queued;
    logic [2:0]       drop_flag;
    logic [CNT_W-1:0] svc_cnt1;
    logic [CNT_W-1:0] svc_cnt2;
    logic [CNT_W-1:0] svc_cnt3;

    modport master (
        output key_in, mask,
        output interrupt1_running, interrupt2_running, interrupt3_running,
        output interrupt1_done, interrupt2_done, interrupt3_done,
        input  interrupt1, interrupt2, interrupt3,
        input  pending, queued, drop_flag,
        input  svc_cnt1, svc_cnt2, svc_cnt3
    );

    modport slave (
        input  key_in, mask,
        input  interrupt1_running, interrupt2_running, interrupt3_running,
        input  interrupt1_done, interrupt2_done, interrupt3_done,
        output interrupt1, interrupt2, interrupt3,
        output pending, queued, drop_flag,
        output svc_cnt1, svc_cnt2, svc_cnt3
    );
endinterface

// File: rtl/irq_request_ctrl.sv
// Three-level interrupt request front end: sync, edge detect,
// per-level request/service FSM with one-deep re-request queue.
module irq_request_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input logic              clk,
    input logic              clr,
    irq_request_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_ACT
    } state_e;

    localparam logic [2:0] FILL_MAX = 3'(SYNC_STAGES + 1);

    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] hist_q;
    logic [2:0] rise_q;
    logic [2:0] fill_q;
    logic [2:0] fill_d;
    logic       fill_done;

    state_e           state_q [3];
    logic [2:0]       irq_q;
    logic [2:0]       queued_q;
    logic [2:0]       drop_q;
    logic [CNT_W-1:0] cnt_q [3];

    logic [2:0] run;
    logic [2:0] done;

    assign run  = {bus.interrupt3_running, bus.interrupt2_running,
                   bus.interrupt1_running};
    assign done = {bus.interrupt3_done, bus.interrupt2_done,
                   bus.interrupt1_done};

    // History is only trusted once the pipeline holds real post-reset
    // samples, so a key held through reset release cannot fake an edge.
    assign fill_done = (fill_q == FILL_MAX);
    assign fill_d    = fill_done ? fill_q : fill_q + 3'd1;

    // Synchroniser chain, history flop and registered rise pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
            rise_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q[0] <= bus.key_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= fill_done ? (sync_q[SYNC_STAGES-1] & ~hist_q) : '0;
            fill_q <= fill_d;
        end
    end

    // Per-level request FSM with registered request, queue, drop, count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int n = 0; n < 3; n++) begin
                state_q[n] <= S_IDLE;
                cnt_q[n]   <= '0;
            end
            irq_q    <= '0;
            queued_q <= '0;
            drop_q   <= '0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                unique case (state_q[n])
                    S_IDLE: begin
                        if (rise_q[n] && bus.mask[n]) begin
                            state_q[n] <= S_PEND;
                            irq_q[n]   <= 1'b1;
                        end
                    end
                    S_PEND: begin
                        if (!bus.mask[n]) begin
                            state_q[n] <= S_IDLE;
                            irq_q[n]   <= 1'b0;
                        end else if (run[n]) begin
                            state_q[n] <= S_ACT;
                            irq_q[n]   <= 1'b0;
                        end
                    end
                    S_ACT: begin
                        // A rise lands before done; a second one is lost.
                        if (rise_q[n] && queued_q[n]) begin
                            drop_q[n] <= 1'b1;
                        end
                        if (done[n]) begin
                            cnt_q[n]    <= cnt_q[n] + CNT_W'(1);
                            queued_q[n] <= 1'b0;
                            if (queued_q[n] || rise_q[n]) begin
                                state_q[n] <= S_PEND;
                                irq_q[n]   <= 1'b1;
                            end else begin
                                state_q[n] <= S_IDLE;
                            end
                        end else if (rise_q[n]) begin
                            queued_q[n] <= 1'b1;
                        end
                    end
                    default: begin
                        state_q[n] <= S_IDLE;
                        irq_q[n]   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.interrupt1 = irq_q[0];
    assign bus.interrupt2 = irq_q[1];
    assign bus.interrupt3 = irq_q[2];
    assign bus.pending    = irq_q;
    assign bus.queued     = queued_q;
    assign bus.drop_flag  = drop_q;
    assign bus.svc_cnt1   = cnt_q[0];
    assign bus.svc_cnt2   = cnt_q[1];
    assign bus.svc_cnt3   = cnt_q[2];
endmodule

// File: tb/tb_irq_request_ctrl.sv
// Bench for irq_request_ctrl: reference model compared every cycle,
// plus directed literal expectations for each scenario.
module tb_irq_request_ctrl;
    localparam int IDLE = 0;
    localparam int PEND = 1;
    localparam int ACT  = 2;

    logic clk;
    logic clr;
    int   checks   = 0;
    int   failures = 0;

    irq_request_ctrl_if #(.CNT_W(8)) bus ();

    irq_request_ctrl #(
        .SYNC_STAGES(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] irqv;
    logic [2:0] runv;
    logic [2:0] donev;
    logic [7:0] cntv [3];
    assign irqv    = {bus.interrupt3, bus.interrupt2, bus.interrupt1};
    assign runv    = {bus.interrupt3_running, bus.interrupt2_running,
                      bus.interrupt1_running};
    assign donev   = {bus.interrupt3_done, bus.interrupt2_done,
                      bus.interrupt1_done};
    assign cntv[0] = bus.svc_cnt1;
    assign cntv[1] = bus.svc_cnt2;
    assign cntv[2] = bus.svc_cnt3;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a request edge reaches the FSM when the key was
    // high 3 edges ago and low 4 edges ago (only post-reset samples).
    int         m_st  [3] = '{IDLE, IDLE, IDLE};
    bit         m_q   [3] = '{0, 0, 0};
    bit         m_drop[3] = '{0, 0, 0};
    int         m_cnt [3] = '{0, 0, 0};
    logic [2:0] m_hist[$];

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int n = 0; n < 3; n++) begin
                m_st[n]   = IDLE;
                m_q[n]    = 0;
                m_drop[n] = 0;
                m_cnt[n]  = 0;
            end
            m_hist.delete();
        end else begin
            logic [2:0] r;
            bit qq;
            r = 3'b000;
            if (m_hist.size() >= 4) r = m_hist[2] & ~m_hist[3];
            for (int n = 0; n < 3; n++) begin
                if (m_st[n] == IDLE) begin
                    if (r[n] && bus.mask[n]) m_st[n] = PEND;
                end else if (m_st[n] == PEND) begin
                    if (!bus.mask[n]) m_st[n] = IDLE;
                    else if (runv[n]) m_st[n] = ACT;
                end else begin
                    qq = m_q[n];
                    if (r[n]) begin
                        if (qq) m_drop[n] = 1;
                        else qq = 1;
                    end
                    if (donev[n]) begin
                        m_cnt[n] = (m_cnt[n] + 1) % 256;
                        m_st[n]  = qq ? PEND : IDLE;
                        qq       = 0;
                    end
                    m_q[n] = qq;
                end
            end
            m_hist.push_front(bus.key_in);
            if (m_hist.size() > 4) void'(m_hist.pop_back());
        end
    end

    // Cycle compare of every output against the model.
    always @(negedge clk) begin
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("cmp_int%0d", n + 1), 32'(irqv[n]),
                32'(m_st[n] == PEND));
            chk($sformatf("cmp_pending%0d", n), 32'(bus.pending[n]),
                32'(m_st[n] == PEND));
            chk($sformatf("cmp_queued%0d", n), 32'(bus.queued[n]),
                32'(m_q[n]));
            chk($sformatf("cmp_drop%0d", n), 32'(bus.drop_flag[n]),
                32'(m_drop[n]));
            chk($sformatf("cmp_cnt%0d", n + 1), 32'(cntv[n]),
                32'(m_cnt[n]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int b);
        bus.key_in[b] = 1'b1;
        tick(2);
        bus.key_in[b] = 1'b0;
        tick(2);
    endtask

    task automatic set_run(input int b, input logic v);
        case (b)
            0: bus.interrupt1_running = v;
            1: bus.interrupt2_running = v;
            default: bus.interrupt3_running = v;
        endcase
    endtask

    task automatic set_done(input int b, input logic v);
        case (b)
            0: bus.interrupt1_done = v;
            1: bus.interrupt2_done = v;
            default: bus.interrupt3_done = v;
        endcase
    endtask

    task automatic serve(input int b);
        set_run(b, 1'b1);
        tick(1);
        set_run(b, 1'b0);
        set_done(b, 1'b1);
        tick(1);
        set_done(b, 1'b0);
    endtask

    initial begin
        clr        = 1'b1;
        bus.key_in = 3'b000;
        bus.mask   = 3'b000;
        for (int b = 0; b < 3; b++) begin
            set_run(b, 1'b0);
            set_done(b, 1'b0);
        end
        tick(3);
        chk("rst_int", 32'(irqv), 32'h0);
        chk("rst_drop", 32'(bus.drop_flag), 32'h0);
        chk("rst_cnt1", 32'(bus.svc_cnt1), 32'h0);
        clr      = 1'b0;
        bus.mask = 3'b111;
        tick(8);

        // Single request, level 2
        bus.key_in[1] = 1'b1;
        tick(3);
        chk("lat_early", 32'(bus.interrupt2), 32'h0);
        tick(1);
        chk("lat_int2", 32'(bus.interrupt2), 32'h1);
        chk("lat_pend", 32'(bus.pending), 32'h2);
        bus.key_in[1] = 1'b0;
        tick(4);
        set_run(1, 1'b1);
        tick(1);
        chk("ack_int2", 32'(bus.interrupt2), 32'h0);
        chk("ack_pend", 32'(bus.pending), 32'h0);
        tick(9);
        set_done(1, 1'b1);
        tick(1);
        set_done(1, 1'b0);
        set_run(1, 1'b0);
        chk("svc2_one", 32'(bus.svc_cnt2), 32'h1);
        set_done(1, 1'b1);
        tick(1);
        set_done(1, 1'b0);
        tick(1);
        chk("idle_done", 32'(bus.svc_cnt2), 32'h1);

        // Queue and drop, level 3
        pulse(2);
        chk("q_int3", 32'(bus.interrupt3), 32'h1);
        set_run(2, 1'b1);
        tick(1);
        set_run(2, 1'b0);
        chk("q_ack", 32'(bus.interrupt3), 32'h0);
        pulse(2);
        chk("q_first", 32'(bus.queued), 32'h4);
        chk("q_nodrop", 32'(bus.drop_flag), 32'h0);
        pulse(2);
        chk("q_drop", 32'(bus.drop_flag), 32'h4);
        pulse(2);
        chk("q_drop2", 32'(bus.drop_flag), 32'h4);
        set_done(2, 1'b1);
        tick(1);
        set_done(2, 1'b0);
        chk("q_rereq", 32'(bus.interrupt3), 32'h1);
        chk("q_clear", 32'(bus.queued), 32'h0);
        chk("q_cnt3", 32'(bus.svc_cnt3), 32'h1);
        serve(2);
        chk("q_cnt3b", 32'(bus.svc_cnt3), 32'h2);
        chk("q_idle", 32'(bus.interrupt3), 32'h0);

        // Masking, level 1
        bus.mask = 3'b110;
        pulse(0);
        tick(2);
        chk("m_noint", 32'(bus.interrupt1), 32'h0);
        chk("m_nodrop", 32'(bus.drop_flag[0]), 32'h0);
        bus.mask = 3'b111;
        tick(2);
        pulse(0);
        chk("m_int1", 32'(bus.interrupt1), 32'h1);
        bus.mask = 3'b110;
        tick(1);
        chk("m_disc", 32'(bus.interrupt1), 32'h0);
        chk("m_pend", 32'(bus.pending[0]), 32'h0);
        bus.mask = 3'b111;
        tick(2);
        chk("m_stay", 32'(bus.interrupt1), 32'h0);

        // Simultaneous done and rise, level 1
        pulse(0);
        set_run(0, 1'b1);
        tick(1);
        set_run(0, 1'b0);
        bus.key_in[0] = 1'b1;
        tick(3);
        set_done(0, 1'b1);
        tick(1);
        set_done(0, 1'b0);
        bus.key_in[0] = 1'b0;
        chk("s_int1", 32'(bus.interrupt1), 32'h1);
        chk("s_queued", 32'(bus.queued[0]), 32'h0);
        chk("s_drop", 32'(bus.drop_flag[0]), 32'h0);
        chk("s_cnt1", 32'(bus.svc_cnt1), 32'h1);
        serve(0);
        chk("s_cnt1b", 32'(bus.svc_cnt1), 32'h2);
        tick(2);

        // Counter wrap, level 1
        for (int i = 0; i < 254; i++) begin
            pulse(0);
            serve(0);
            if (i == 252) chk("w_255", 32'(bus.svc_cnt1), 32'hff);
        end
        chk("w_wrap", 32'(bus.svc_cnt1), 32'h0);

        // Asynchronous reset during service
        pulse(2);
        set_run(2, 1'b1);
        tick(1);
        set_run(2, 1'b0);
        pulse(2);
        chk("r_queued", 32'(bus.queued), 32'h4);
        @(posedge clk);
        #2;
        clr           = 1'b1;
        bus.key_in[2] = 1'b1;
        #1;
        chk("r_int", 32'(irqv), 32'h0);
        chk("r_queued0", 32'(bus.queued), 32'h0);
        chk("r_drop0", 32'(bus.drop_flag), 32'h0);
        chk("r_cnt3", 32'(bus.svc_cnt3), 32'h0);
        tick(2);
        clr = 1'b0;
        tick(10);
        chk("r_noreq", 32'(bus.interrupt3), 32'h0);
        chk("r_nopend", 32'(bus.pending), 32'h0);
        set_done(2, 1'b1);
        tick(1);
        set_done(2, 1'b0);
        tick(1);
        chk("r_nocnt", 32'(bus.svc_cnt3), 32'h0);
        bus.key_in[2] = 1'b0;
        tick(3);
        pulse(2);
        chk("r_rearm", 32'(bus.interrupt3), 32'h1);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
